// File: rtl/evo_pkg.sv
// Shared types and helpers for the evolvable-hardware fitness evaluator.
package evo_pkg;

  // Evaluator sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Bits needed to hold a match count from 0 up to NUM_OUT * 2^NUM_IN.
  function automatic int unsigned score_width(input int unsigned num_in,
                                              input int unsigned num_out);
    return $clog2(num_out * (32'd1 << num_in) + 32'd1);
  endfunction

endpackage : evo_pkg

// File: rtl/match_count.sv
// Counts how many observed output bits agree with the expected bits.
// An unknown observed bit never counts as a match: the if-condition
// evaluates unknown and falls through to the else branch.
module match_count #(
  parameter int unsigned N  = 2,
  parameter int unsigned CW = $clog2(N + 32'd1)
) (
  input  logic [N-1:0]  obs_i,
  input  logic [N-1:0]  exp_i,
  output logic [CW-1:0] count_o
);

  // Population count of agreeing bit positions.
  always_comb begin
    count_o = {CW{1'b0}};
    for (int k = 0; k < int'(N); k++) begin
      if (~(obs_i[k] ^ exp_i[k])) begin
        count_o = count_o + CW'(32'd1);
      end else begin
        count_o = count_o;
      end
    end
  end

endmodule : match_count

// File: rtl/fitness_evaluator.sv
// Walks a candidate circuit through every input vector, lets it settle,
// samples its outputs and scores them against a latched truth table.
module fitness_evaluator
  import evo_pkg::*;
#(
  parameter int unsigned NUM_IN        = 4,
  parameter int unsigned NUM_OUT       = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic                                       abort,
  input  logic [NUM_OUT*(2**NUM_IN)-1:0]             target,
  output logic [NUM_IN-1:0]                          dut_in,
  input  logic [NUM_OUT-1:0]                         dut_out,
  output logic                                       busy,
  output logic                                       done,
  output logic [score_width(NUM_IN, NUM_OUT)-1:0]    score,
  output logic                                       perfect
);

  localparam int unsigned NUM_VEC = 2 ** NUM_IN;
  localparam int unsigned TBITS   = NUM_OUT * NUM_VEC;
  localparam int unsigned SW      = score_width(NUM_IN, NUM_OUT);
  localparam int unsigned CW      = $clog2(NUM_OUT + 32'd1);

  localparam logic [7:0]        LAST_CNT  = 8'(SETTLE_CYCLES - 32'd1);
  localparam logic [NUM_IN-1:0] LAST_IDX  = {NUM_IN{1'b1}};
  localparam logic [SW-1:0]     FULL_SCORE = SW'(TBITS);

  state_e              state_q, state_d;
  logic [NUM_IN-1:0]   idx_q, idx_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [TBITS-1:0]    target_q, target_d;
  logic [SW-1:0]       score_q, score_d;
  logic                busy_q, done_q, perfect_q;
  logic [NUM_OUT-1:0]  exp_bits;
  logic [CW-1:0]       match_cnt;

  assign exp_bits = target_q[idx_q * NUM_OUT +: NUM_OUT];

  match_count #(
    .N  (NUM_OUT),
    .CW (CW)
  ) u_match_count (
    .obs_i   (dut_out),
    .exp_i   (exp_bits),
    .count_o (match_cnt)
  );

  // Next-state and datapath updates; abort from any busy state wins.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    score_d  = score_q;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      idx_d   = {NUM_IN{1'b0}};
      cnt_d   = 8'd0;
      score_d = {SW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            target_d = target;
            score_d  = {SW{1'b0}};
            idx_d    = {NUM_IN{1'b0}};
            cnt_d    = 8'd0;
            state_d  = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = 8'd0;
            state_d = ST_SAMPLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_SAMPLE: begin
          score_d = score_q + SW'(match_cnt);
          if (idx_q == LAST_IDX) begin
            state_d = ST_FINISH;
          end else begin
            idx_d   = idx_q + NUM_IN'(32'd1);
            state_d = ST_SETTLE;
          end
        end
        ST_FINISH: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= {NUM_IN{1'b0}};
      cnt_q     <= 8'd0;
      target_q  <= {TBITS{1'b0}};
      score_q   <= {SW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      perfect_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      score_q   <= score_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_FINISH);
      perfect_q <= (score_d == FULL_SCORE);
    end
  end

  assign dut_in  = idx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign score   = score_q;
  assign perfect = perfect_q;

endmodule : fitness_evaluator

// File: tb/tb_fitness_evaluator.sv
// Self-checking bench for fitness_evaluator at default parameters.
module tb_fitness_evaluator;

  localparam int NV    = 16;
  localparam int NO    = 2;
  localparam int TB    = NV * NO;
  localparam int S     = 4;
  localparam int LAT   = NV * (S + 1) + 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] target;
  logic [3:0]  dut_in;
  logic [1:0]  dut_out;
  logic        busy;
  logic        done;
  logic [5:0]  score;
  logic        perfect;

  // Candidate circuit model: truth table plus per-output unknown mask.
  logic [31:0] cand_tt;
  logic [1:0]  xmask;

  int n_checks;
  int n_err;

  fitness_evaluator dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .target  (target),
    .dut_in  (dut_in),
    .dut_out (dut_out),
    .busy    (busy),
    .done    (done),
    .score   (score),
    .perfect (perfect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Candidate circuit responds combinationally to the applied vector.
  always_comb begin
    dut_out = 2'b00;
    for (int k = 0; k < NO; k++) begin
      if (xmask[k]) dut_out[k] = 1'bx;
      else          dut_out[k] = cand_tt[int'(dut_in) * NO + k];
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: number of (vector, output) pairs where the candidate agrees
  // with the target; an unknown candidate output never agrees.
  function automatic int model_score(input logic [31:0] tt, input logic [31:0] tgt,
                                     input logic [1:0] xm);
    int m = 0;
    for (int v = 0; v < NV; v++)
      for (int k = 0; k < NO; k++)
        if (!xm[k] && (tt[v*NO+k] == tgt[v*NO+k])) m++;
    return m;
  endfunction

  // One complete run; optionally pokes start and target mid-run.
  task automatic run_eval(input logic [31:0] tgt, input int exp_score,
                          input bit disturb, input string tag);
    int cyc, done_at, done_cnt, busy_after, exp_in;
    @(negedge clk);
    target = tgt;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; done_at = 0; done_cnt = 0; busy_after = -1;
    chk({tag, "_busy_c1"}, busy, 1);
    while (cyc <= 200) begin
      if (cyc <= LAT) begin
        exp_in = (cyc - 1) / (S + 1);
        if (exp_in > NV - 1) exp_in = NV - 1;
        chk({tag, "_dut_in"}, dut_in, exp_in);
      end
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = cyc;
      end
      if (done_at != 0 && cyc == done_at + 1) busy_after = busy;
      if (disturb) begin
        start = (cyc == 5 || cyc == 40 || cyc == LAT) ? 1'b1 : 1'b0;
        if (cyc == 30) target = ~tgt;
      end
      if (done_at != 0 && cyc > done_at + 3) break;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, done_at, LAT);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_busy_after"}, busy_after, 0);
    chk({tag, "_score"}, score, exp_score);
    chk({tag, "_perfect"}, perfect, (exp_score == TB) ? 1 : 0);
  endtask

  initial begin
    logic probe;
    logic [31:0] rt, rtt;
    int cyc, dcnt;
    n_checks = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; target = 32'd0;
    cand_tt = 32'd0; xmask = 2'b00;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_score", score, 0);
    chk("rst_perfect", perfect, 0);
    chk("rst_dut_in", dut_in, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Candidate implements the target exactly.
    cand_tt = 32'hA5C3_96F0;
    run_eval(32'hA5C3_96F0, model_score(cand_tt, 32'hA5C3_96F0, 2'b00), 1'b0, "exact");

    // Outputs tied low.
    cand_tt = 32'h0000_0000;
    run_eval(32'hFFFF_FFFF, model_score(cand_tt, 32'hFFFF_FFFF, 2'b00), 1'b0, "zero_vs_ones");
    run_eval(32'h0000_0000, model_score(cand_tt, 32'h0000_0000, 2'b00), 1'b0, "zero_vs_zero");

    // Constant output pattern 2'b01.
    cand_tt = {16{2'b01}};
    run_eval(32'h5555_5555, model_score(cand_tt, 32'h5555_5555, 2'b00), 1'b0, "const01");

    // Output1 stuck unknown: only meaningful where the simulator keeps X.
    probe = 1'bx;
    if ($isunknown(probe)) begin
      xmask = 2'b10;
      run_eval(32'h5555_5555, model_score(cand_tt, 32'h5555_5555, 2'b10), 1'b0, "stuck_x");
      xmask = 2'b00;
    end

    // Random candidates and targets.
    for (int i = 0; i < 4; i++) begin
      rtt = $urandom;
      rt  = (i == 0) ? rtt ^ 32'h0000_0001 : $urandom;
      cand_tt = rtt;
      run_eval(rt, model_score(rtt, rt, 2'b00), 1'b0, "random");
    end

    // Extra starts and a target change mid-run leave the run untouched.
    cand_tt = $urandom;
    rt = $urandom;
    run_eval(rt, model_score(cand_tt, rt, 2'b00), 1'b1, "disturb");

    // Abort on cycle 20.
    cand_tt = 32'h1234_5678;
    @(negedge clk);
    target = 32'h1234_5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < 20) begin @(negedge clk); cyc++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_dut_in", dut_in, 0);
    chk("abort_score", score, 0);
    dcnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("abort_no_done", dcnt, 0);
    run_eval(32'h1234_5678, model_score(cand_tt, 32'h1234_5678, 2'b00), 1'b0, "after_abort");

    // Abort while idle changes nothing.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_score", score, TB);
    chk("idle_abort_busy", busy, 0);

    // Asynchronous reset in the middle of a settle window.
    cand_tt = 32'hFFFF_0000;
    @(negedge clk);
    target = 32'hFFFF_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < 12) begin @(negedge clk); cyc++; end
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_score", score, 0);
    chk("arst_perfect", perfect, 0);
    chk("arst_dut_in", dut_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rt = 32'hC3C3_3C3C;
    run_eval(rt, model_score(cand_tt, rt, 2'b00), 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_fitness_evaluator

// File: doc/fitness_evaluator.md
FITNESS_EVALUATOR -- requirements
Module: fitness_evaluator

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, meaning candidate circuit input count (vectors = 2^NUM_IN).
REQ-002 SHALL have parameter NUM_OUT, default 2, meaning candidate circuit output count.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, range 1..255, meaning clk cycles held per vector before sampling.
REQ-004 SHALL have port clk, input, 1, sole clock; all state rising-edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port start, input, 1, request an evaluation run.
REQ-007 SHALL have port abort, input, 1, cancel the run in progress.
REQ-008 SHALL have port target, input, NUM_OUT*2^NUM_IN, expected truth table; bit v*NUM_OUT+k is the expected value of output k for input vector v.
REQ-009 SHALL have port dut_in, output, NUM_IN, drives candidate inputs (bit i -> inputi).
REQ-010 SHALL have port dut_out, input, NUM_OUT, candidate outputs (bit k <- outputk).
REQ-011 SHALL have port busy, output, 1, high while a run is active.
REQ-012 SHALL have port done, output, 1, single-cycle pulse at run completion.
REQ-013 SHALL have port score, output, clog2(NUM_OUT*2^NUM_IN+1) (6 at defaults), count of matching output bits.
REQ-014 SHALL have port perfect, output, 1, high when score equals NUM_OUT*2^NUM_IN.

Function
REQ-015 SHALL implement states IDLE, SETTLE, SAMPLE, FINISH.
REQ-016 In IDLE with start=1: SHALL latch target, clear score, set vector index 0, drive dut_in=0, enter SETTLE.
REQ-017 SETTLE SHALL hold dut_in stable for exactly SETTLE_CYCLES cycles, then enter SAMPLE.
REQ-018 SAMPLE (one cycle) SHALL compare each dut_out bit against the latched target bits for the current vector and add the match count (0..NUM_OUT) to score.
REQ-019 A dut_out bit that is X or Z SHALL count as a mismatch.
REQ-020 After SAMPLE: if index = 2^NUM_IN-1, enter FINISH; else increment index, drive dut_in=index, enter SETTLE.
REQ-021 FINISH SHALL assert done for one cycle and return to IDLE; score and perfect SHALL hold until the next accepted start.
REQ-022 Run latency from start-accept edge to done SHALL be 2^NUM_IN*(SETTLE_CYCLES+1)+1 cycles (81 at defaults).
REQ-023 busy SHALL be high from the cycle after start-accept through the FINISH cycle inclusive.
REQ-024 start while busy SHALL be ignored; changes to target after start-accept SHALL not affect the run.
REQ-025 abort while busy SHALL return to IDLE next cycle, set dut_in=0 and score=0, and produce no done; abort takes priority over start in the same cycle; abort in IDLE SHALL do nothing.
REQ-026 start in the FINISH cycle SHALL be ignored (accepted only in IDLE).
REQ-027 score SHALL never overflow; its width covers the full match count.

Reset
REQ-028 On rst_n low: state IDLE, dut_in=0, busy=0, done=0, score=0, perfect=0, index=0, settle counter=0, immediately and regardless of clk.
REQ-029 Reset mid-run SHALL discard the run with no done pulse; operation resumes on the first clk edge after rst_n deasserts.

Structure
REQ-030 State encoding enum and the score-width function SHALL live in shared package evo_pkg.
REQ-031 The per-vector bit-match counter SHALL be a sub-module match_count (combinational popcount of ~(dut_out ^ expected)), instantiated once.

Verification
REQ-032 Defaults, dut_out driven as bitwise model of target, target=32'hA5C3_96F0, start -> done at cycle 81, score=32, perfect=1.
REQ-033 dut_out tied to 2'b00, target=32'hFFFF_FFFF -> score=0, perfect=0; target=0 -> score=32.
REQ-034 dut_out=2'b01 constant, target=32'h5555_5555 -> score=32; same stimulus with output1 bit stuck X -> score=16.
REQ-035 abort asserted on cycle 20 of a run -> busy low next cycle, dut_in=0, no done, score=0; next start runs a full 81 cycles.
REQ-036 start pulsed on cycles 5 and 40 of a run and target changed mid-run -> single done at cycle 81, score from the originally latched target.
REQ-037 rst_n asserted asynchronously mid-SETTLE -> all outputs zero before next clk edge; restarted run gives the correct score.
